gerador_paridade_serial: RTL and testbench
==========================================

// Module: gerador_paridade_serial
// PURPOSE
//   Transmit end of the 5-bit parity link: accepts a 5-bit word (b1..b5) on a
//   valid/ready handshake and computes its even-parity bit bp. It sends the
//   frame serially on tx as: START, b1..b5, bp, STOP. It also drives the
//   latched word and bp in parallel so they can feed verificador_paridade
//   directly. Sits between the data source and the serial line.
// PARAMETERS
//   CLKS_PER_BIT  4  clock cycles per serial bit (>=1)
//   PARITY_ODD    0  0: even parity, bp = b1^b2^b3^b4^b5; 1: odd parity, bp = ~(that)
// PORTS
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  asynchronous reset, active-low
//   b1..b5   in   1  data bits; b1 is the first bit on the line
//   valid    in   1  source offers b1..b5 this cycle
//   ready    out  1  block can accept a word (IDLE only)
//   tx       out  1  serial line, idles high
//   busy     out  1  frame in progress (not IDLE)
//   q1..q5   out  1  latched data word, held until the next accept
//   bp       out  1  parity of the latched word, held until the next accept
// BEHAVIOUR
//   Reset (async, rst_n=0):
//   - tx=1, ready=1, busy=0, q1..q5=0, bp=0.
//   - FSM goes to IDLE and the bit counter and divider clear.
//   - A frame in progress is abandoned, with no partial STOP.
//   Accept:
//   - Occurs on the rising edge where valid && ready.
//   - b1..b5 are captured into q1..q5 and the shift register.
//   - bp is computed from the captured bits and registered on the same edge.
//   - Inputs are ignored while ready=0.
//   FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE
//   - IDLE: tx=1, ready=1. Goes to START on accept.
//   - START: tx=0 for CLKS_PER_BIT cycles.
//   - DATA: tx=q1, then q2 .. q5, each for CLKS_PER_BIT cycles. A 3-bit index
//     counts 0..4 and leaves DATA after index 4 completes.
//   - PARITY: tx=bp for CLKS_PER_BIT cycles.
//   - STOP: tx=1 for CLKS_PER_BIT cycles, then returns to IDLE.
//   Timing:
//   - tx is registered. It drops to 0 on the first edge after the accept
//     edge (latency 1 cycle).
//   - Frame length is 8*CLKS_PER_BIT cycles from tx falling to IDLE.
//   - ready=0 for the whole frame and returns to 1 on the edge that ends STOP.
//   - Minimum spacing is one IDLE cycle. If valid is held high, the next word
//     is accepted in that IDLE cycle, so a new frame starts
//     8*CLKS_PER_BIT+1 cycles after the previous accept.
//   Divider:
//   - Counts 0..CLKS_PER_BIT-1 and wraps.
//   - The bit advances on the wrap.
//   - The divider resets to 0 on each state change.
//   busy = (state != IDLE) and is the exact complement of ready.
//   Guarantee: {q1..q5,bp} always has even weight (odd weight if PARITY_ODD=1).
//   The verificador_paridade fed from these outputs reports no error.
// TESTING
//   1. Reset check. Hold rst_n=0 with valid=1. Required: tx=1, ready=1, busy=0,
//      bp=0, q=0. No accept occurs.
//   2. Single frame, CLKS_PER_BIT=4, b1..b5=1,0,1,1,0. Required: bp=1.
//      tx=0,1,0,1,1,0,1,1, with each bit held 4 cycles. ready returns high
//      after 32 cycles.
//   3. All-zero word 0,0,0,0,0. Required: bp=0, tx parity slot=0.
//      With PARITY_ODD=1 the same word gives bp=1.
//   4. Back-to-back frames: valid held high with 1,1,1,1,1 and then 0,0,0,0,1.
//      Required: frames separated by exactly 1 IDLE cycle; bp=1 then bp=1.
//      Inputs that change mid-frame do not alter tx.
//   5. Reset mid-frame: drop rst_n during the DATA bit for b3. Required: tx=1
//      immediately, with no STOP slot. After release, a new word is accepted
//      and sent correctly.
//   6. Exhaustive: all 32 words fed to verificador_paridade via q1..q5/bp.
//      Required: no parity error is flagged. The deserialised tx matches the
//      inputs for every word.

Source files
------------

// File: rtl/gerador_paridade_serial.sv
// gerador_paridade_serial: serial transmitter of a 5-bit word framed as START, b1..b5, parity, STOP.
// Revision 1.0 - initial release
`default_nettype none

module gerador_paridade_serial #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  input  logic b4,
  input  logic b5,
  input  logic valid,
  output logic ready,
  output logic tx,
  output logic busy,
  output logic q1,
  output logic q2,
  output logic q3,
  output logic q4,
  output logic q5,
  output logic bp
);

  localparam int c_DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] c_S_IDLE   = 3'd0;
  localparam logic [2:0] c_S_START  = 3'd1;
  localparam logic [2:0] c_S_DATA   = 3'd2;
  localparam logic [2:0] c_S_PARITY = 3'd3;
  localparam logic [2:0] c_S_STOP   = 3'd4;

  logic [2:0]         r_state;
  logic [c_DIV_W-1:0] r_div;
  logic [2:0]         r_idx;
  logic [4:0]         r_q;
  logic [4:0]         r_shift;
  logic               r_bp;
  logic               r_tx;

  logic w_wrap;
  logic w_accept;
  logic w_par;
  logic w_tx_next;

  assign w_wrap   = (r_div == c_DIV_LAST);
  assign w_accept = valid && (r_state == c_S_IDLE);
  assign w_par    = (b1 ^ b2 ^ b3 ^ b4 ^ b5) ^ PARITY_ODD;

  // tx is registered from the current state, so it lags the state by one edge
  always_comb begin
    w_tx_next = 1'b1;
    case (r_state)
      c_S_START:  w_tx_next = 1'b0;
      c_S_DATA:   w_tx_next = r_shift[0];
      c_S_PARITY: w_tx_next = r_bp;
      default:    w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_S_IDLE;
      r_div   <= '0;
      r_idx   <= '0;
      r_q     <= '0;
      r_shift <= '0;
      r_bp    <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_tx <= w_tx_next;
      case (r_state)
        c_S_IDLE: begin
          r_div <= '0;
          if (w_accept) begin
            r_state <= c_S_START;
            r_q     <= {b5, b4, b3, b2, b1};
            r_shift <= {b5, b4, b3, b2, b1};
            r_bp    <= w_par;
          end
        end
        c_S_START: begin
          if (w_wrap) begin
            r_state <= c_S_DATA;
            r_idx   <= '0;
            r_div   <= '0;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        c_S_DATA: begin
          if (w_wrap) begin
            r_div   <= '0;
            r_shift <= {1'b0, r_shift[4:1]};
            if (r_idx == 3'd4) begin
              r_state <= c_S_PARITY;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        c_S_PARITY: begin
          if (w_wrap) begin
            r_state <= c_S_STOP;
            r_div   <= '0;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        c_S_STOP: begin
          if (w_wrap) begin
            r_state <= c_S_IDLE;
            r_div   <= '0;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        default: begin
          r_state <= c_S_IDLE;
          r_div   <= '0;
        end
      endcase
    end
  end

  assign ready = (r_state == c_S_IDLE);
  assign busy  = ~ready;
  assign tx    = r_tx;
  assign q1    = r_q[0];
  assign q2    = r_q[1];
  assign q3    = r_q[2];
  assign q4    = r_q[3];
  assign q5    = r_q[4];
  assign bp    = r_bp;

endmodule

`default_nettype wire

// File: tb/tb_gerador_paridade_serial.sv
// tb_gerador_paridade_serial: self-checking bench for the serial parity transmitter.
// Revision 1.0 - initial release
`default_nettype none

module tb_gerador_paridade_serial;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] b = 5'b0;
  logic valid = 1'b0;

  logic ready, tx, busy, q1, q2, q3, q4, q5, bp;
  logic o_ready, o_tx, o_busy, o1, o2, o3, o4, o5, o_bp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gerador_paridade_serial #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .b1(b[0]), .b2(b[1]), .b3(b[2]), .b4(b[3]), .b5(b[4]),
    .valid(valid), .ready(ready), .tx(tx), .busy(busy),
    .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .bp(bp)
  );

  gerador_paridade_serial #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) u_odd (
    .clk(clk), .rst_n(rst_n),
    .b1(b[0]), .b2(b[1]), .b3(b[2]), .b4(b[3]), .b5(b[4]),
    .valid(valid), .ready(o_ready), .tx(o_tx), .busy(o_busy),
    .q1(o1), .q2(o2), .q3(o3), .q4(o4), .q5(o5), .bp(o_bp)
  );

  logic [4:0] q;
  assign q = {q5, q4, q3, q2, q1};

  typedef struct {
    logic [4:0] word;
    logic       exp_bp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference parity: count the ones in the word; even parity sets bp when the count is odd
  function automatic logic ref_bp(input logic [4:0] w, input logic odd);
    return logic'(($countones(w) % 2) != 0) ^ odd;
  endfunction

  // Called at the negedge right after the accept edge; follows the frame for 8*CPB edges
  task automatic watch_frame(input logic [4:0] w);
    logic exp_frame [8];
    logic [4:0] rx;
    exp_frame[0] = 1'b0;
    for (int k = 0; k < 5; k++) exp_frame[k+1] = w[k];
    exp_frame[6] = ref_bp(w, 1'b0);
    exp_frame[7] = 1'b1;
    rx = '0;
    check("q_latched", 32'(q), 32'(w));
    check("bp_even", 32'(bp), 32'(ref_bp(w, 1'b0)));
    check("bp_odd", 32'(o_bp), 32'(ref_bp(w, 1'b1)));
    check("verif_no_error", 32'(^{q, bp}), 32'd0);
    check("busy_after_accept", 32'({busy, ready}), 32'b10);
    for (int n = 1; n <= 8 * CPB; n++) begin
      @(posedge clk);
      @(negedge clk);
      if ((n - 1) % CPB == CPB / 2) begin
        check($sformatf("tx_slot%0d", (n - 1) / CPB), 32'(tx), 32'(exp_frame[(n - 1) / CPB]));
        if ((n - 1) / CPB >= 1 && (n - 1) / CPB <= 5) rx[(n - 1) / CPB - 1] = tx;
      end
      if (n == 8 * CPB - 1) check("ready_low_end", 32'(ready), 32'd0);
      if (n == 8 * CPB) check("ready_back", 32'({ready, busy}), 32'b10);
    end
    check("deserialised", 32'(rx), 32'(w));
  endtask

  task automatic send_word(input logic [4:0] w);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    b = w;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    b = $urandom_range(0, 31);
    watch_frame(w);
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{5'b01101, 1'b1};
    vecs[1] = '{5'b00000, 1'b0};
    vecs[2] = '{5'b11111, 1'b1};
    vecs[3] = '{5'b10000, 1'b1};
    vecs[4] = '{5'b00011, 1'b0};

    // Reset held with valid asserted: nothing may be accepted
    rst_n = 1'b0;
    valid = 1'b1;
    b = 5'b11111;
    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({tx, ready, busy, bp}), 32'b1100);
    check("rst_q", 32'(q), 32'd0);
    check("rst_odd_bp", 32'(o_bp), 32'd0);
    valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_rst", 32'({tx, ready, busy}), 32'b110);

    // Table vectors
    for (int i = 0; i < 5; i++) begin
      send_word(vecs[i].word);
      check($sformatf("table_bp%0d", i), 32'(bp), 32'(vecs[i].exp_bp));
    end

    // Back-to-back with valid held; inputs change mid-frame
    @(negedge clk);
    b = 5'b11111;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b = 5'b10000;
    watch_frame(5'b11111);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    check("b2b_gap_one_idle", 32'({ready, tx}), 32'b01);
    watch_frame(5'b10000);

    // Reset during the b3 slot (b3=0 so tx is low before the reset)
    @(negedge clk);
    b = 5'b11011;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (3 * CPB + 1) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("tx_b3_before_rst", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midframe_rst_tx", 32'({tx, ready, busy}), 32'b110);
    check("midframe_rst_q", 32'({q, bp}), 32'd0);
    repeat (2) @(negedge clk);
    check("rst_hold_tx", 32'(tx), 32'd1);
    rst_n = 1'b1;
    send_word(5'b10110);

    // Exhaustive words
    for (int w = 0; w < 32; w++) send_word(5'(w));

    // Random words
    for (int r = 0; r < 8; r++) send_word(5'($urandom_range(0, 31)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
